// File: rtl/adder_pkg.sv
// Shared definitions for the multi-limb add/subtract sequencer.
package adder_pkg;

  localparam int LIMB_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the limb counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_64.sv
// 64-bit adder built from 4-bit lookahead groups chained at group level.
module carry_lookahead_adder_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        cin_i,
  output logic [63:0] sum_o,
  output logic        cout_o,
  output logic        p_o,
  output logic        g_o
);

  logic [63:0] p, g, c_bit;
  logic [15:0] gp, gg;
  logic [16:0] c_grp;
  logic        blk_g;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Group propagate/generate, group carries, and bit carries inside each group.
  always_comb begin
    gp       = '0;
    gg       = '0;
    c_grp    = '0;
    c_bit    = '0;
    blk_g    = 1'b0;
    c_grp[0] = cin_i;
    for (int n = 0; n < 16; n++) begin
      gp[n] = &p[4*n +: 4];
      gg[n] = g[4*n+3]
            | (p[4*n+3] & g[4*n+2])
            | (p[4*n+3] & p[4*n+2] & g[4*n+1])
            | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
      c_grp[n+1] = gg[n] | (gp[n] & c_grp[n]);
      blk_g      = gg[n] | (gp[n] & blk_g);
      c_bit[4*n] = c_grp[n];
      for (int j = 1; j < 4; j++) begin
        c_bit[4*n+j] = g[4*n+j-1] | (p[4*n+j-1] & c_bit[4*n+j-1]);
      end
    end
  end

  assign sum_o  = p ^ c_bit;
  assign cout_o = c_grp[16];
  assign p_o    = &gp;
  assign g_o    = blk_g;

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-cycle W-bit add/subtract: one shared 64-bit adder, one limb per cycle,
// least-significant limb first, carry held in a register between limbs.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | adding limb k each cycle
// DONE  | result valid, held until out_ready
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LIMB_W*LIMBS-1:0] op_a,
  input  logic [LIMB_W*LIMBS-1:0] op_b,
  input  logic                  op_sub,
  input  logic                  op_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LIMB_W*LIMBS-1:0] result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero,
  output logic                  busy
);

  localparam int W  = LIMB_W * LIMBS;
  localparam int KW = cnt_w(LIMBS);
  localparam logic [KW-1:0] K_LAST = KW'(LIMBS - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            nz_q, nz_d;

  int              limb_base;
  logic [LIMB_W-1:0] add_a, add_b, add_sum;
  logic            add_cout;
  logic            unused_p, unused_g;

  logic accept, last_limb;

  assign limb_base = int'(k_q) * LIMB_W;
  assign add_a     = a_q[limb_base +: LIMB_W];
  assign add_b     = b_q[limb_base +: LIMB_W];
  assign accept    = (state_q == IDLE) && in_valid;
  assign last_limb = (k_q == K_LAST);

  carry_lookahead_adder_64 u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .p_o    (unused_p),
    .g_o    (unused_g)
  );

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_limb) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch on accept, limb update while running.
  always_comb begin
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    nz_d     = nz_q;
    if (accept) begin
      a_d     = op_a;
      b_d     = op_sub ? ~op_b : op_b;
      carry_d = op_sub | op_cin;
      k_d     = '0;
      nz_d    = 1'b0;
    end else if (state_q == RUN) begin
      result_d[limb_base +: LIMB_W] = add_sum;
      carry_d = add_cout;
      nz_d    = nz_q | (|add_sum);
      if (last_limb) begin
        cout_d = add_cout;
        // Operand signs come from the stored (possibly inverted) operands.
        ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[LIMB_W-1] != a_q[W-1]);
        zero_d = ~(nz_q | (|add_sum));
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      nz_q     <= 1'b0;
    end else begin
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      nz_q     <= nz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench: a 4-limb instance for the main scenarios, a 1-limb
// instance for single-cycle latency and randomized back-to-back requests.
module tb_multiword_add_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-limb instance
  logic         in_valid, in_ready, op_sub, op_cin, out_valid, out_ready;
  logic [255:0] op_a, op_b, result;
  logic         cout, ovf, zero, busy;

  // 1-limb instance
  logic         in_valid1, in_ready1, op_sub1, op_cin1, out_valid1, out_ready1;
  logic [63:0]  op_a1, op_b1, result1;
  logic         cout1, ovf1, zero1, busy1;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  localparam logic [255:0] ALL1   = {256{1'b1}};
  localparam logic [255:0] MAXPOS = {1'b0, {255{1'b1}}};
  localparam logic [255:0] MINNEG = {1'b1, 255'b0};
  localparam logic [255:0] M2     = {{255{1'b1}}, 1'b0};

  multiword_add_sequencer #(.LIMBS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .busy(busy)
  );

  multiword_add_sequencer #(.LIMBS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .op_cin(op_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
    .cout(cout1), .ovf(ovf1), .zero(zero1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to the 4-limb instance from IDLE and check the result.
  task automatic req4(input string tag, input logic [255:0] a, input logic [255:0] b,
                      input logic sub, input logic cin, input logic [255:0] er,
                      input logic eco, input logic eov, input logic ez, input bit release_hs);
    int lat;
    op_a = a; op_b = b; op_sub = sub; op_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~a; op_b = ~b; op_sub = ~sub; op_cin = ~cin;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  256'(lat), 256'd4);
    chk({tag, ".res"},  result, er);
    chk({tag, ".cout"}, 256'(cout), 256'(eco));
    chk({tag, ".ovf"},  256'(ovf), 256'(eov));
    chk({tag, ".zero"}, 256'(zero), 256'(ez));
    if (release_hs) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Issue one request to the 1-limb instance and compare against an arithmetic model.
  task automatic req1(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic sub, input logic cin);
    int          lat;
    logic [63:0] bop;
    logic [64:0] s;
    logic        eov;
    bop = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bop} + 65'(sub | cin);
    eov = (a[63] == bop[63]) && (s[63] != a[63]);
    op_a1 = a; op_b1 = b; op_sub1 = sub; op_cin1 = cin; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; op_a1 = ~a; op_b1 = ~b;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  256'(lat), 256'd1);
    chk({tag, ".res"},  256'(result1), 256'(s[63:0]));
    chk({tag, ".cout"}, 256'(cout1), 256'(s[64]));
    chk({tag, ".ovf"},  256'(ovf1), 256'(eov));
    chk({tag, ".zero"}, 256'(zero1), 256'(s[63:0] == 64'd0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; op_sub1 = 1'b0; op_cin1 = 1'b0; out_ready1 = 1'b1;
    #3;
    chk("rst.in_ready",  256'(in_ready), 256'd1);
    chk("rst.out_valid", 256'(out_valid), 256'd0);
    chk("rst.busy",      256'(busy), 256'd0);
    chk("rst.result",    result, 256'd0);
    chk("rst.flags",     256'({cout, ovf, zero}), 256'd0);
    chk("rst1.result",   256'(result1), 256'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    req4("add_wrap", ALL1, 256'd1, 1'b0, 1'b0, 256'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    req4("sub_borrow", 256'd5, 256'd7, 1'b1, 1'b0, M2, 1'b0, 1'b0, 1'b0, 1'b1);
    req4("ovf_pos", MAXPOS, 256'd1, 1'b0, 1'b0, MINNEG, 1'b0, 1'b1, 1'b0, 1'b1);
    req4("ovf_neg", MINNEG, 256'd1, 1'b1, 1'b0, MAXPOS, 1'b1, 1'b1, 1'b0, 1'b1);
    req4("limb_carry", {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0, 1'b0,
         {191'd0, 1'b1, 64'd0}, 1'b0, 1'b0, 1'b0, 1'b1);
    req4("sub_eq", 256'd1234, 256'd1234, 1'b1, 1'b1, 256'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    req4("bp", 256'd1, 256'd2, 1'b0, 1'b0, 256'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.out_valid", 256'(out_valid), 256'd1);
      chk("bp.result",    result, 256'd3);
      chk("bp.in_ready",  256'(in_ready), 256'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.rel_in_ready",  256'(in_ready), 256'd1);
    chk("bp.rel_out_valid", 256'(out_valid), 256'd0);

    // A request offered in the same cycle as the DONE handshake is not taken.
    req4("cin_add", 256'd10, 256'd20, 1'b0, 1'b1, 256'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    op_a = 256'd100; op_b = 256'd1; op_sub = 1'b0; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("nobypass.in_ready", 256'(in_ready), 256'd1);
    chk("nobypass.busy",     256'(busy), 256'd0);
    req4("after_done", 256'd100, 256'd1, 1'b0, 1'b0, 256'd101, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while limb 2 is being processed.
    op_a = ALL1; op_b = 256'd0; op_sub = 1'b0; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid.busy",     256'(busy), 256'd1);
    chk("mid.in_ready", 256'(in_ready), 256'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_out_valid", 256'(out_valid), 256'd0);
    chk("mid.rst_in_ready",  256'(in_ready), 256'd1);
    chk("mid.rst_busy",      256'(busy), 256'd0);
    chk("mid.rst_result",    result, 256'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.no_valid", 256'(out_valid), 256'd0);
    req4("post_rst", 256'd3, 256'd4, 1'b0, 1'b0, 256'd7, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single-limb instance.
    req1("l1_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("l1_carry.hand_res",  256'(result1), 256'd0);
    chk("l1_carry.hand_cout", 256'(cout1), 256'd1);
    req1("l1_sub_eq", 64'hDEAD_BEEF_0000_1111, 64'hDEAD_BEEF_0000_1111, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      req1("l1_rand", {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
